// File: rtl/axis_variable_delay.sv
// axis_variable_delay: runtime-programmable sample delay line on an AXI4-Stream path.
// Latency: one cycle from input accept to the registered output beat.
// Backpressure: input is ready only when the output register is empty or draining this cycle.
module axis_variable_delay #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int ADDR_WIDTH       = 5
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [ADDR_WIDTH-1:0]       cfg_delay,
    output logic                        sts_primed,
    output logic                        s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid
);
    localparam int                  DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FILL_MAX = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] FILL_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [AXIS_TDATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0]       wr_ptr;
    logic [ADDR_WIDTH-1:0]       delay_reg;
    logic [ADDR_WIDTH-1:0]       rd_idx;
    logic [ADDR_WIDTH:0]         fill;
    logic                        aresetn_q;
    logic                        accept;
    logic                        have_history;
    logic [AXIS_TDATA_WIDTH-1:0] sel_dat;

    // Ready is held off for one cycle after reset release so the first edge sees settled state.
    assign s_axis_tready = aresetn_q & (~m_axis_tvalid | m_axis_tready);
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign rd_idx        = wr_ptr - delay_reg;
    assign have_history  = (fill >= {1'b0, delay_reg});
    assign sts_primed    = have_history;

    always_comb begin
        sel_dat = '0;
        if (delay_reg == '0) begin
            sel_dat = s_axis_tdata;
        end else if (have_history) begin
            sel_dat = mem[rd_idx];
        end
    end

    // History storage is deliberately not reset; fill gates every read of stale entries.
    always_ff @(posedge aclk) begin
        if (accept) begin
            mem[wr_ptr] <= s_axis_tdata;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aresetn_q     <= 1'b0;
            wr_ptr        <= '0;
            fill          <= '0;
            delay_reg     <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
        end else begin
            aresetn_q <= 1'b1;
            delay_reg <= cfg_delay;
            if (accept) begin
                wr_ptr        <= wr_ptr + PTR_ONE;
                if (fill != FILL_MAX) begin
                    fill <= fill + FILL_ONE;
                end
                m_axis_tdata  <= sel_dat;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axis_variable_delay.sv
// Directed bench for axis_variable_delay with a queue scoreboard fed by a delay-line model.
module tb_axis_variable_delay;
    localparam int W  = 32;
    localparam int AW = 5;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b1;
    logic [AW-1:0] cfg_delay = '0;
    logic          sts_primed;
    logic          s_axis_tready;
    logic [W-1:0]  s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          m_axis_tready = 1'b1;
    logic [W-1:0]  m_axis_tdata;
    logic          m_axis_tvalid;

    int total  = 0;
    int passes = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] hist[$];
    logic [AW-1:0] model_delay;

    axis_variable_delay #(.AXIS_TDATA_WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cfg_delay     (cfg_delay),
        .sts_primed    (sts_primed),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid)
    );

    always #5 aclk = ~aclk;

    // Delay value in force for a beat accepted at the next edge.
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) model_delay <= '0;
        else          model_delay <= cfg_delay;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passes++;
        else $error("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    // Output side of the scoreboard: a beat leaves at the next edge when valid & ready.
    always @(negedge aclk) begin
        if (aresetn === 1'b1 && m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 64'(m_axis_tdata), 64'hdead_beef_dead_beef);
            end else begin
                chk("out_data", 64'(m_axis_tdata), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic send(input logic [W-1:0] d);
        int n;
        int dly;
        logic [W-1:0] e;
        bit ok;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        n  = 0;
        ok = 0;
        while (n < 50) begin
            @(negedge aclk);
            if (s_axis_tready === 1'b1) begin
                ok = 1;
                break;
            end
            n++;
        end
        if (!ok) begin
            total++;
            $error("FAIL send_timeout: got no ready, expected ready within 50 cycles");
        end else begin
            dly = int'(model_delay);
            if (dly == 0)               e = d;
            else if (hist.size() < dly) e = '0;
            else                        e = hist[hist.size() - dly];
            exp_q.push_back(e);
            hist.push_back(d);
        end
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        #1;
        chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
        chk("rst_m_tdata", 64'(m_axis_tdata), 64'd0);
        chk("rst_primed", 64'(sts_primed), 64'd1);
        exp_q.delete();
        hist.delete();
        repeat (2) @(posedge aclk);
        #3;
        aresetn = 1'b1;
        #1;
        chk("rel_ready_low", 64'(s_axis_tready), 64'd0);
        @(posedge aclk);
        #1;
        chk("rel_ready_high", 64'(s_axis_tready), 64'd1);
    endtask

    task automatic set_delay(input logic [AW-1:0] d);
        cfg_delay = d;
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #2;
        cfg_delay = 3;
        do_reset();

        // Ramp at delay 3: outputs 0,0,0,1,2,3; primed after the third accept.
        for (int i = 1; i <= 6; i++) begin
            send(W'(i));
            if (i == 2) chk("primed_after2", 64'(sts_primed), 64'd0);
            if (i == 3) chk("primed_after3", 64'(sts_primed), 64'd1);
            if (i == 4) chk("ramp_first_data", 64'(m_axis_tdata), 64'd1);
        end

        // Zero delay: pass-through, visible one cycle after accept.
        set_delay(0);
        for (int i = 10; i <= 12; i++) begin
            send(W'(i));
            chk("zero_dly_vld", 64'(m_axis_tvalid), 64'd1);
            chk("zero_dly_dat", 64'(m_axis_tdata), 64'(i));
        end

        // Backpressure at delay 1 with a stalled input beat pending.
        set_delay(1);
        for (int i = 20; i <= 23; i++) send(W'(i));
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'd99;
        repeat (5) begin
            @(negedge aclk);
            chk("bp_s_tready", 64'(s_axis_tready), 64'd0);
            chk("bp_m_tvalid", 64'(m_axis_tvalid), 64'd1);
            chk("bp_hold_dat", 64'(m_axis_tdata), 64'(exp_q[0]));
            chk("bp_hold_dat_const", 64'(m_axis_tdata), 64'd22);
        end
        @(posedge aclk);
        #1;
        m_axis_tready = 1'b1;
        send(32'd99);
        send(32'd100);
        send(32'd101);

        // Maximum delay with pointer wrap from a fresh history.
        cfg_delay = 31;
        do_reset();
        for (int k = 1; k <= 100; k++) begin
            send(W'(k));
            if (k == 31) chk("max_dly_last_zero", 64'(m_axis_tdata), 64'd0);
            if (k == 32) chk("max_dly_first", 64'(m_axis_tdata), 64'd1);
            if (k == 100) chk("max_dly_wrap", 64'(m_axis_tdata), 64'd69);
        end

        // Live delay change from 2 to 6 reuses stored history.
        set_delay(2);
        for (int i = 200; i <= 209; i++) send(W'(i));
        set_delay(6);
        send(32'd210);
        chk("dly_change_first", 64'(m_axis_tdata), 64'd204);
        for (int i = 211; i <= 213; i++) send(W'(i));

        // Async reset mid-burst at delay 2.
        set_delay(2);
        send(32'd300);
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            send(W'(400 + i));
            if (i == 1) chk("post_rst_zero", 64'(m_axis_tdata), 64'd0);
            if (i == 3) chk("post_rst_first", 64'(m_axis_tdata), 64'd401);
        end

        repeat (3) @(posedge aclk);
        #1;
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end
endmodule

// File: doc/axis_variable_delay.md
# axis_variable_delay

Runtime-programmable sample delay line for an AXI4-Stream data path. Every accepted input beat produces exactly one output beat carrying the input sample from `cfg_delay` accepted beats earlier; zeros are emitted until enough history exists. It sits inline in the ADC/DAC streaming chains wherever a tunable, software-set alignment delay is needed. It supports full backpressure through a registered output stage, asynchronous reset, and on-the-fly delay changes without flushing.

## Interface
- `AXIS_TDATA_WIDTH`, 32, sample width in bits
- `ADDR_WIDTH`, 5, log2 of buffer depth; DEPTH = 2^ADDR_WIDTH; maximum delay = DEPTH-1
- `aclk`  in  1  clock, all logic on rising edge
- `aresetn`  in  1  asynchronous, active-low reset
- `cfg_delay`  in  ADDR_WIDTH  requested delay in accepted beats (0..DEPTH-1)
- `sts_primed`  out  1  high when history count ≥ active delay
- `s_axis_tready`  out  1  input ready
- `s_axis_tdata`  in  AXIS_TDATA_WIDTH  input sample
- `s_axis_tvalid`  in  1  input valid
- `m_axis_tready`  in  1  output ready
- `m_axis_tdata`  out  AXIS_TDATA_WIDTH  delayed sample (registered)
- `m_axis_tvalid`  out  1  output valid (registered)

## Operation
- Storage: DEPTH-entry circular buffer `mem`, indexed by write pointer `wr_ptr` (ADDR_WIDTH bits, wraps modulo DEPTH); uses distributed RAM with a combinational read.
- Delay register: `delay_reg <= cfg_delay` every cycle. An accepted beat uses the `delay_reg` value present in its own cycle.
- History counter `fill`: ADDR_WIDTH+1 bits. It increments on each accepted beat and saturates at DEPTH.
- Accept = `s_axis_tvalid & s_axis_tready`. On accept:
  - `mem[wr_ptr] <= s_axis_tdata`; `wr_ptr <= wr_ptr + 1`.
  - Selected value: if `delay_reg == 0`, it is `s_axis_tdata` (pass-through). Else if `fill < delay_reg`, it is 0. Else it is `mem[(wr_ptr - delay_reg) mod DEPTH]`.
  - `m_axis_tdata <= selected value`; `m_axis_tvalid <= 1`.
- No accept and `m_axis_tready`: `m_axis_tvalid <= 0`. `m_axis_tdata` holds its value.
- `s_axis_tready = aresetn_q & (~m_axis_tvalid | m_axis_tready)`, where `aresetn_q` is a one-flop registered copy of reset release. Ready is therefore 0 during reset and on the first cycle after reset.
- Delay changes: no flush. Increasing the delay reuses the stored history. If the history is insufficient (`fill < new delay`), zeros are output until it is.
- `sts_primed = (fill >= delay_reg)`; this is combinational from registers.
- A `cfg_delay` value ≥ DEPTH is impossible by width.

## Timing
- Reset (`aresetn` low, asynchronous): `wr_ptr=0`, `fill=0`, `delay_reg=0`, `m_axis_tvalid=0`, `m_axis_tdata=0`, `s_axis_tready=0`, `sts_primed=1` (0 ≥ 0). Memory contents are not reset.
- Latency: output appears one cycle after acceptance (registered stage). Throughput is one beat per cycle while `m_axis_tready=1`.
- Backpressure: while `m_axis_tvalid=1` and `m_axis_tready=0`, `s_axis_tready=0`, and `m_axis_tdata`/`m_axis_tvalid` are stable (AXIS hold rule).
- Simultaneous output drain and new accept in the same cycle: the output register is reloaded and `m_axis_tvalid` stays 1, with no bubble.
- Wrap-around: `wr_ptr` wraps from DEPTH-1 to 0; the read index is computed modulo DEPTH, so a delay of DEPTH-1 reads the oldest entry.
- Reset mid-stream: any in-flight output beat is discarded. After release, behaviour is identical to power-up, and zeros are output until history is rebuilt.
- `cfg_delay` change: the new value is registered one cycle later. The first beat accepted at least one cycle after the change uses the new delay.

## Test plan
- Reset then ramp: `cfg_delay=3`, `m_axis_tready=1`, inputs 1,2,3,4,5,6. Required outputs: 0,0,0,1,2,3. `sts_primed` rises after the third accept.
- Zero delay: `cfg_delay=0`, inputs 10,11,12. Required outputs: 10,11,12, each one cycle after its accept.
- Backpressure: `cfg_delay=1`, hold `m_axis_tready=0` for 5 cycles mid-stream. Required: `s_axis_tready=0`, output data stable, no beat lost or duplicated after release.
- Max delay and wrap: `ADDR_WIDTH=5`, `cfg_delay=31`, 100 ramp samples starting at 1. Output k (1-based) must be 0 for k ≤ 31 and k-31 otherwise.
- Delay change: run at delay 2 for 10 beats, then switch to delay 6. Required: once the change is active, the next output equals input(n-6), taken from existing history, with no zeros.
- Async reset mid-burst: assert `aresetn` low between clock edges. Required: `m_axis_tvalid` and `s_axis_tready` drop immediately. After release, `s_axis_tready` returns one cycle later and the output begins with zeros for `cfg_delay` beats.
